trivium_stream: RTL and testbench

- Parametrised word-parallel Trivium keystream generator; successor to the bit-serial encryptor.
- Loads an 80-bit key and IV, runs the 1152-round warm-up, then streams LEN W-bit keystream words over a valid/ready handshake.
- Sits between the key/IV register block and the downstream cipher datapath.

---
 rtl/trivium_pkg.sv | 31 +++
 rtl/trivium_stream_if.sv | 15 +
 rtl/trivium_round.sv | 16 +
 rtl/trivium_stream.sv | 78 +++++++
 tb/tb_trivium_stream.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/trivium_pkg.sv
// trivium_pkg: shared sizes, tap positions, FSM encoding and key/IV helpers for trivium_stream
package trivium_pkg;
  localparam int STATE_W = 288;
  localparam int KEY_W = 80;
  localparam int IV_W = 80;
  localparam int INIT_ROUNDS = 1152;
  localparam int A_OUT0 = 65;
  localparam int A_OUT1 = 92;
  localparam int A_AND0 = 90;
  localparam int A_AND1 = 91;
  localparam int A_FB = 170;
  localparam int B_OUT0 = 161;
  localparam int B_OUT1 = 176;
  localparam int B_AND0 = 174;
  localparam int B_AND1 = 175;
  localparam int B_FB = 263;
  localparam int C_OUT0 = 242;
  localparam int C_OUT1 = 287;
  localparam int C_AND0 = 285;
  localparam int C_AND1 = 286;
  localparam int C_FB = 68;
  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;
  function automatic logic [79:0] byte_rev80(input logic [79:0] x);
    logic [79:0] r;
    for (int b = 0; b < 10; b++) r[8*b +: 8] = x[8*(9-b) +: 8];
    return r;
  endfunction
  function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key, input logic [IV_W-1:0] iv);
    return {3'b111, 112'd0, byte_rev80(iv), 13'd0, byte_rev80(key)};
  endfunction
endpackage

// File: rtl/trivium_stream_if.sv
// trivium_stream_if: keystream valid/ready bus (adds pt_data when TRIVIUM_XOR_EN is defined)
interface trivium_stream_if #(parameter int W = 8);
  logic ks_valid;
  logic ks_ready;
  logic ks_last;
  logic [W-1:0] ks_data;
`ifdef TRIVIUM_XOR_EN
  logic [W-1:0] pt_data;
  modport master(output ks_valid, ks_data, ks_last, input ks_ready, pt_data);
  modport slave(input ks_valid, ks_data, ks_last, output ks_ready, pt_data);
`else
  modport master(output ks_valid, ks_data, ks_last, input ks_ready);
  modport slave(input ks_valid, ks_data, ks_last, output ks_ready);
`endif
endinterface

// File: rtl/trivium_round.sv
// trivium_round: one combinational Trivium round, state in, next state and keystream bit out
module trivium_round import trivium_pkg::*; (
  input  logic [STATE_W-1:0] s,
  output logic [STATE_W-1:0] s_nx,
  output logic               z
);
  logic a, b, c, t1, t2, t3;
  assign a = s[A_OUT0] ^ s[A_OUT1];
  assign b = s[B_OUT0] ^ s[B_OUT1];
  assign c = s[C_OUT0] ^ s[C_OUT1];
  assign z = a ^ b ^ c;
  assign t1 = a ^ (s[A_AND0] & s[A_AND1]) ^ s[A_FB];
  assign t2 = b ^ (s[B_AND0] & s[B_AND1]) ^ s[B_FB];
  assign t3 = c ^ (s[C_AND0] & s[C_AND1]) ^ s[C_FB];
  assign s_nx = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
endmodule

// File: rtl/trivium_stream.sv
// trivium_stream: W-bit-per-cycle Trivium keystream generator with valid/ready output.
// Defining TRIVIUM_XOR_EN makes ks_data carry keystream XOR pt_data instead of raw keystream.
module trivium_stream import trivium_pkg::*; #(
  parameter int W = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [IV_W-1:0]  iv,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  trivium_stream_if.master ks
);
  localparam int N = INIT_ROUNDS / W;
  localparam int CW = $clog2(N + 1);
  state_t state, state_nx;
  logic [STATE_W-1:0] s;
  logic [STATE_W-1:0] chain [W+1];
  logic [W-1:0] z, word;
  logic [CW-1:0] init_cnt;
  logic [LEN_W-1:0] words_left;
  logic load, hs, init_end;
  assign chain[0] = s;
  for (genvar i = 0; i < W; i++) begin : g_round
    trivium_round u_round (.s(chain[i]), .s_nx(chain[i+1]), .z(z[W-1-i]));
  end
`ifdef TRIVIUM_XOR_EN
  assign word = z ^ ks.pt_data;
`else
  assign word = z;
`endif
  always_comb begin
    hs = ks.ks_valid & ks.ks_ready;
    init_end = init_cnt == CW'(N - 1);
    load = (state == RUN) & (!ks.ks_valid | ks.ks_ready) & (words_left != '0);
    busy = state != IDLE;
    done = state == DONE;
    state_nx = state == IDLE ? (start ? INIT : IDLE) :
               state == INIT ? (init_end ? (words_left == '0 ? DONE : RUN) : INIT) :
               state == RUN  ? (hs & ks.ks_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s <= '0;
      init_cnt <= '0;
      words_left <= '0;
      ks.ks_valid <= 1'b0;
      ks.ks_data <= '0;
      ks.ks_last <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        s <= load_state(key, iv);
        words_left <= len;
        init_cnt <= '0;
      end
      if (state == INIT) begin
        s <= chain[W];
        init_cnt <= init_cnt + 1'b1;
      end
      // a stalled word keeps data, last flag and cipher state frozen
      if (load) begin
        s <= chain[W];
        ks.ks_data <= word;
        ks.ks_valid <= 1'b1;
        ks.ks_last <= words_left == LEN_W'(1);
        words_left <= words_left - 1'b1;
      end else if (hs) begin
        ks.ks_valid <= 1'b0;
        ks.ks_last <= 1'b0;
      end
    end
endmodule

// File: tb/tb_trivium_stream.sv
// tb_trivium_stream: randomized bench for trivium_stream against a bit-serial reference model
module tb_trivium_stream;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic start8 = 1'b0, start64 = 1'b0;
  logic [79:0] key = '0, iv = '0;
  logic [15:0] len = '0;
  logic busy8, done8, busy64, done64;
  int checks = 0, errors = 0, done_cnt = 0;
  bit ref_bits[$];
  trivium_stream_if #(.W(8)) if8();
  trivium_stream_if #(.W(64)) if64();
`ifdef TRIVIUM_XOR_EN
  localparam logic [63:0] PT = {8{8'hA5}};
  assign if8.pt_data = PT[7:0];
  assign if64.pt_data = PT;
`else
  localparam logic [63:0] PT = '0;
`endif
  trivium_stream #(.W(8), .LEN_W(16)) d8 (.clk(clk), .reset(reset), .start(start8), .key(key), .iv(iv),
    .len(len), .busy(busy8), .done(done8), .ks(if8.master));
  trivium_stream #(.W(64), .LEN_W(16)) d64 (.clk(clk), .reset(reset), .start(start64), .key(key), .iv(iv),
    .len(len), .busy(busy64), .done(done64), .ks(if64.master));
  always @(posedge clk) if (done8) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic gen_ref(input logic [79:0] k, input logic [79:0] v, input int n);
    bit s[288];
    bit t1, t2, t3;
    ref_bits.delete();
    foreach (s[j]) s[j] = 1'b0;
    for (int b = 0; b < 10; b++)
      for (int i = 0; i < 8; i++) begin
        s[8*b+i] = k[8*(9-b)+i];
        s[93+8*b+i] = v[8*(9-b)+i];
      end
    s[285] = 1'b1; s[286] = 1'b1; s[287] = 1'b1;
    for (int r = 0; r < 1152 + n; r++) begin
      t1 = s[65] ^ s[92];
      t2 = s[161] ^ s[176];
      t3 = s[242] ^ s[287];
      if (r >= 1152) ref_bits.push_back(t1 ^ t2 ^ t3);
      t1 ^= (s[90] & s[91]) ^ s[170];
      t2 ^= (s[174] & s[175]) ^ s[263];
      t3 ^= (s[285] & s[286]) ^ s[68];
      for (int j = 287; j > 0; j--) s[j] = s[j-1];
      s[0] = t3; s[93] = t1; s[177] = t2;
    end
  endtask

  function automatic logic [63:0] ref_word(input int idx, input int w);
    logic [63:0] r = '0;
    logic [63:0] m = (64'd1 << w) - 64'd1;
    for (int i = 0; i < w; i++) r[w-1-i] = ref_bits[idx*w+i];
    return r ^ (PT & m);
  endfunction

  task automatic run8(input logic [79:0] k, input logic [79:0] v, input int n, input int st0,
                      input int stn, input int exp_first, input bit poke);
    int got = 0, e = 0, first = -1, sc = 0, d0;
    logic [7:0] hd = '0;
    logic hl = 1'b0;
    bit held = 0;
    gen_ref(k, v, n * 8);
    d0 = done_cnt;
    @(negedge clk);
    key = k; iv = v; len = n[15:0]; start8 = 1'b1; if8.ks_ready = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    while (got < n && e < 4000) begin
      start8 = poke && e == 50;
      if (poke && e == 50) key = ~k;
      if8.ks_ready = !(got == st0 && sc < stn);
      if (if8.ks_valid) begin
        if (first < 0) first = e;
        if (if8.ks_ready) begin
          check($sformatf("w8[%0d]", got), if8.ks_data, ref_word(got, 8));
          check("last8", if8.ks_last, got == n - 1);
          got++; held = 0;
        end else begin
          if (held) begin
            check("stall_data", if8.ks_data, hd);
            check("stall_last", if8.ks_last, hl);
          end
          hd = if8.ks_data; hl = if8.ks_last; held = 1; sc++;
        end
      end
      @(posedge clk); e++; #1;
    end
    start8 = 1'b0;
    check("count8", got, n);
    if (exp_first >= 0) check("first8", first, exp_first);
    check("done8", done8, 1);
    check("valid_after_last", if8.ks_valid, 0);
    @(posedge clk); #1;
    check("done8_off", done8, 0);
    check("idle8", busy8, 0);
    check("done8_count", done_cnt - d0, 1);
  endtask

  task automatic run64(input logic [79:0] k, input logic [79:0] v, input int n);
    int got = 0, e = 0, first = -1;
    gen_ref(k, v, n * 64);
    @(negedge clk);
    key = k; iv = v; len = n[15:0]; start64 = 1'b1; if64.ks_ready = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    while (got < n && e < 1000) begin
      if (if64.ks_valid) begin
        if (first < 0) first = e;
        check($sformatf("w64[%0d]", got), if64.ks_data, ref_word(got, 64));
        check("last64", if64.ks_last, got == n - 1);
        got++;
      end
      @(posedge clk); e++; #1;
    end
    check("count64", got, n);
    check("first64", first, 19);
    check("done64", done64, 1);
    @(posedge clk); #1;
    check("idle64", busy64, 0);
  endtask

  initial begin : main
    int d0, vseen, dedge;
    if8.ks_ready = 1'b1;
    if64.ks_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy8, 0);
    check("rst_valid", if8.ks_valid, 0);
    check("rst_data", if8.ks_data, 0);
    check("rst_last", if8.ks_last, 0);
    check("rst_done", done8, 0);
    @(negedge clk) reset = 1'b1;
    run8(80'h0, 80'h0, 4, -1, 0, 145, 0);
    run8(80'h0102030405060708090A, {80{1'b1}}, 256, -1, 0, 145, 0);
    run64(80'h0102030405060708090A, {80{1'b1}}, 32);
    run8(80'({$urandom, $urandom, $urandom}), 80'({$urandom, $urandom, $urandom}), 10, 3, 5, 145, 1);
    for (int t = 0; t < 2; t++)
      run8(80'({$urandom, $urandom, $urandom}), 80'({$urandom, $urandom, $urandom}),
           $urandom_range(1, 24), $urandom_range(0, 3), 5, -1, 0);
    // zero-length request: full warm-up, no words, one done
    d0 = done_cnt; vseen = 0; dedge = -1;
    @(negedge clk);
    key = 80'({$urandom, $urandom, $urandom}); len = '0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int e = 1; e <= 300; e++) begin
      @(posedge clk); #1;
      if (if8.ks_valid) vseen++;
      if (done8 && dedge < 0) dedge = e;
    end
    check("zl_valid", vseen, 0);
    check("zl_done_edge", dedge, 144);
    check("zl_done_cnt", done_cnt - d0, 1);
    check("zl_idle", busy8, 0);
    // asynchronous reset in the middle of a stream
    @(negedge clk);
    key = 80'({$urandom, $urandom, $urandom}); iv = 80'({$urandom, $urandom, $urandom});
    len = 16'd20; start8 = 1'b1; if8.ks_ready = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check("pre_rst_valid", if8.ks_valid, 1);
    d0 = done_cnt;
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy8, 0);
    check("arst_valid", if8.ks_valid, 0);
    check("arst_data", if8.ks_data, 0);
    check("arst_last", if8.ks_last, 0);
    check("arst_done", done8, 0);
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_done", done_cnt - d0, 0);
    @(negedge clk) reset = 1'b1;
    run8(80'({$urandom, $urandom, $urandom}), 80'({$urandom, $urandom, $urandom}), 6, 2, 5, 145, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
